// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI memory controller.
// The arbiter and the transaction sequencer both import this package.
package idli_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    DUMMY = 3'd3,
    DATA  = 3'd4,
    END   = 3'd5
  } sqi_state_t;

  typedef enum logic {
    SRC_FCH = 1'b0,
    SRC_LSU = 1'b1
  } sqi_src_t;

  localparam logic [7:0] SQI_CMD_RD    = 8'h03;
  localparam logic [7:0] SQI_CMD_WR    = 8'h02;
  localparam int         SQI_DUMMY_CYC = 2;

  // Nibble idx of a 24b address; idx 5 is the first nibble sent.
  function automatic logic [3:0] nib_sel(input logic [23:0] v, input logic [2:0] idx);
    case (idx)
      3'd0:    nib_sel = v[3:0];
      3'd1:    nib_sel = v[7:4];
      3'd2:    nib_sel = v[11:8];
      3'd3:    nib_sel = v[15:12];
      3'd4:    nib_sel = v[19:16];
      3'd5:    nib_sel = v[23:20];
      default: nib_sel = 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/idli_sqi_arb_m.sv
// Two-way round-robin arbiter between fetch and LSU, one decision per transaction.
// A tie goes to whichever source did not win the previous grant.
module idli_sqi_arb_m
  import idli_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       fch_req,
  input  logic       lsu_req,
  input  logic       en,
  output logic [1:0] gnt
);

  sqi_src_t last;

  // gnt[0] = fetch, gnt[1] = LSU
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (fch_req && lsu_req) gnt = (last == SRC_LSU) ? 2'b01 : 2'b10;
      else                    gnt = {lsu_req, fch_req};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last <= SRC_LSU;
    else if (|gnt) last <= gnt[1] ? SRC_LSU : SRC_FCH;
  end

endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// SQI serial-RAM controller: sequences 16b word reads/writes nibble by nibble,
// sharing the memory between instruction fetch and the load/store unit.
module idli_sqi_ctrl_m
  import idli_pkg::*;
#(
  parameter int         ADDR_W    = 16,
  parameter logic [7:0] CMD_RD    = SQI_CMD_RD,
  parameter logic [7:0] CMD_WR    = SQI_CMD_WR,
  parameter int         DUMMY_CYC = SQI_DUMMY_CYC
) (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst,
  input  logic              i_sqi_fch_req,
  input  logic [ADDR_W-1:0] i_sqi_fch_addr,
  output logic              o_sqi_fch_ack,
  input  logic              i_sqi_lsu_req,
  input  logic              i_sqi_lsu_wr,
  input  logic [ADDR_W-1:0] i_sqi_lsu_addr,
  output logic              o_sqi_lsu_ack,
  input  logic [3:0]        i_sqi_lsu_wdata,
  output logic              o_sqi_lsu_wdata_rdy,
  output logic [3:0]        o_sqi_rd_data,
  output logic              o_sqi_rd_vld,
  output logic              o_sqi_rd_src,
  output logic              o_sqi_cs_n,
  output logic [3:0]        o_sqi_sio_out,
  output logic              o_sqi_sio_oe,
  input  logic [3:0]        i_sqi_sio_in,
  output sqi_state_t        o_sqi_dbg_state
);

  localparam int PAD_W = 23 - ADDR_W;

  sqi_state_t        state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic [1:0]        gnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  sqi_src_t          src_q;
  logic [23:0]       baddr;
  logic [7:0]        cmd;
  logic              in_data;

  // Handshake: a requester holds req (with addr/wr stable) until it sees a
  // one-cycle ack; ack is the grant, issued only in IDLE and never under reset.
  idli_sqi_arb_m u_arb (
    .clk     (i_sqi_gck),
    .rst     (i_sqi_rst),
    .fch_req (i_sqi_fch_req),
    .lsu_req (i_sqi_lsu_req),
    .en      ((state == IDLE) && !i_sqi_rst),
    .gnt     (gnt)
  );

  assign o_sqi_fch_ack   = gnt[0];
  assign o_sqi_lsu_ack   = gnt[1];
  assign o_sqi_dbg_state = state;

  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      src_q  <= SRC_FCH;
    end else if (|gnt) begin
      wr_q   <= gnt[1] & i_sqi_lsu_wr;
      addr_q <= gnt[1] ? i_sqi_lsu_addr : i_sqi_fch_addr;
      src_q  <= gnt[1] ? SRC_LSU : SRC_FCH;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 3'd1;
    case (state)
      IDLE: begin
        cnt_nx = 3'd0;
        if (|gnt) state_nx = CMD;
      end
      CMD: if (cnt == 3'd1) begin
        state_nx = ADDR;
        cnt_nx   = 3'd0;
      end
      ADDR: if (cnt == 3'd5) begin
        state_nx = (wr_q || DUMMY_CYC == 0) ? DATA : DUMMY;
        cnt_nx   = 3'd0;
      end
      DUMMY: if (cnt == 3'(DUMMY_CYC - 1)) begin
        state_nx = DATA;
        cnt_nx   = 3'd0;
      end
      DATA: if (cnt == 3'd3) begin
        state_nx = END;
        cnt_nx   = 3'd0;
      end
      END: begin
        state_nx = IDLE;
        cnt_nx   = 3'd0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 3'd0;
      end
    endcase
  end

  assign baddr   = {{PAD_W{1'b0}}, addr_q, 1'b0};
  assign cmd     = wr_q ? CMD_WR : CMD_RD;
  assign in_data = (state == DATA);

  always_comb begin
    o_sqi_cs_n          = !(state inside {CMD, ADDR, DUMMY, DATA});
    o_sqi_sio_oe        = (state == CMD) || (state == ADDR) || (in_data && wr_q);
    o_sqi_lsu_wdata_rdy = in_data && wr_q;
    o_sqi_rd_vld        = in_data && !wr_q;
    o_sqi_rd_data       = o_sqi_rd_vld ? i_sqi_sio_in : 4'h0;
    o_sqi_rd_src        = o_sqi_rd_vld && (src_q == SRC_LSU);
    o_sqi_sio_out       = 4'h0;
    case (state)
      CMD:     o_sqi_sio_out = (cnt == 3'd0) ? cmd[7:4] : cmd[3:0];
      ADDR:    o_sqi_sio_out = nib_sel(baddr, 3'd5 - cnt);
      DATA:    if (wr_q) o_sqi_sio_out = i_sqi_lsu_wdata;
      default: o_sqi_sio_out = 4'h0;
    endcase
  end

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed bench for idli_sqi_ctrl_m: reads, writes, arbitration and reset abort,
// with every pin checked cycle by cycle against hand-derived expectations.
module tb_idli_sqi_ctrl_m;
  import idli_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fch_req = 1'b0;
  logic [15:0] fch_addr = 16'h0;
  logic        fch_ack;
  logic        lsu_req = 1'b0;
  logic        lsu_wr = 1'b0;
  logic [15:0] lsu_addr = 16'h0;
  logic        lsu_ack;
  logic [3:0]  lsu_wdata = 4'h0;
  logic        wdata_rdy;
  logic [3:0]  rd_data;
  logic        rd_vld;
  logic        rd_src;
  logic        cs_n;
  logic [3:0]  sio_out;
  logic        sio_oe;
  logic [3:0]  sio_in = 4'h0;
  sqi_state_t  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  idli_sqi_ctrl_m dut (
    .i_sqi_gck           (clk),
    .i_sqi_rst           (rst),
    .i_sqi_fch_req       (fch_req),
    .i_sqi_fch_addr      (fch_addr),
    .o_sqi_fch_ack       (fch_ack),
    .i_sqi_lsu_req       (lsu_req),
    .i_sqi_lsu_wr        (lsu_wr),
    .i_sqi_lsu_addr      (lsu_addr),
    .o_sqi_lsu_ack       (lsu_ack),
    .i_sqi_lsu_wdata     (lsu_wdata),
    .o_sqi_lsu_wdata_rdy (wdata_rdy),
    .o_sqi_rd_data       (rd_data),
    .o_sqi_rd_vld        (rd_vld),
    .o_sqi_rd_src        (rd_src),
    .o_sqi_cs_n          (cs_n),
    .o_sqi_sio_out       (sio_out),
    .o_sqi_sio_oe        (sio_oe),
    .i_sqi_sio_in        (sio_in),
    .o_sqi_dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after inputs are set at a negedge while the DUT should be in IDLE.
  task automatic chk_idle(input string tag, input logic e_fch, input logic e_lsu);
    chk({tag, " state"}, 16'(dbg_state), 16'(IDLE));
    chk({tag, " cs_n"}, 16'(cs_n), 16'h1);
    chk({tag, " oe"}, 16'(sio_oe), 16'h0);
    chk({tag, " sio_out"}, 16'(sio_out), 16'h0);
    chk({tag, " rd_vld"}, 16'(rd_vld), 16'h0);
    chk({tag, " fch_ack"}, 16'(fch_ack), 16'(e_fch));
    chk({tag, " lsu_ack"}, 16'(lsu_ack), 16'(e_lsu));
  endtask

  // Steps cycles G+1.. of a granted transaction, checking every pin each cycle.
  task automatic run_txn(input string tag, input logic [15:0] addr, input bit wr,
                         input bit src, input logic [15:0] data, input bit drop,
                         input int raise_k, input int abort_k);
    logic [23:0] b;
    logic [7:0]  c;
    logic [3:0]  nib, e_sio;
    logic [15:0] sh;
    logic [23:0] bsh;
    int          dstart, last_k;
    bit          in_data;
    string       t;
    b      = {7'd0, addr, 1'b0};
    c      = wr ? 8'h02 : 8'h03;
    dstart = wr ? 9 : 11;
    last_k = dstart + 4;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      if (k == 1 && drop) begin
        fch_req = 1'b0;
        lsu_req = 1'b0;
      end
      if (k == raise_k) lsu_req = 1'b1;
      in_data = (k >= dstart) && (k < dstart + 4);
      nib = 4'h0;
      if (in_data) begin
        sh  = data >> (4 * (dstart + 3 - k));
        nib = sh[3:0];
      end
      if (!wr && in_data)                             sio_in = nib;
      else if (!wr && (k == 9 || k == 10))            sio_in = 4'hF;
      else                                            sio_in = 4'h0;
      lsu_wdata = (wr && in_data) ? nib : 4'h7;
      #1;
      e_sio = 4'h0;
      if (k == 1)               e_sio = c[7:4];
      else if (k == 2)          e_sio = c[3:0];
      else if (k <= 8) begin
        bsh   = b >> (4 * (8 - k));
        e_sio = bsh[3:0];
      end
      else if (wr && in_data)   e_sio = nib;
      t = $sformatf("%s G+%0d", tag, k);
      chk({t, " cs_n"}, 16'(cs_n), 16'(k == last_k));
      chk({t, " oe"}, 16'(sio_oe), 16'((k <= 8) || (wr && in_data)));
      chk({t, " sio_out"}, 16'(sio_out), 16'(e_sio));
      chk({t, " rd_vld"}, 16'(rd_vld), 16'(!wr && in_data));
      chk({t, " rd_data"}, 16'(rd_data), 16'((!wr && in_data) ? nib : 4'h0));
      chk({t, " rd_src"}, 16'(rd_src), 16'((!wr && in_data) ? src : 1'b0));
      chk({t, " wdata_rdy"}, 16'(wdata_rdy), 16'(wr && in_data));
      chk({t, " fch_ack"}, 16'(fch_ack), 16'h0);
      chk({t, " lsu_ack"}, 16'(lsu_ack), 16'h0);
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        chk({t, " abort state"}, 16'(dbg_state), 16'(IDLE));
        chk({t, " abort cs_n"}, 16'(cs_n), 16'h1);
        chk({t, " abort oe"}, 16'(sio_oe), 16'h0);
        chk({t, " abort rd_vld"}, 16'(rd_vld), 16'h0);
        chk({t, " abort fch_ack"}, 16'(fch_ack), 16'h0);
        return;
      end
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    chk_idle("reset", 1'b0, 1'b0);
    chk("reset wdata_rdy", 16'(wdata_rdy), 16'h0);
    chk("reset rd_data", 16'(rd_data), 16'h0);
    chk("reset rd_src", 16'(rd_src), 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fetch read 0x0012 returning A,B,C,D
    @(negedge clk);
    fch_req  = 1'b1;
    fch_addr = 16'h0012;
    #1;
    chk_idle("fch_rd G", 1'b1, 1'b0);
    run_txn("fch_rd", 16'h0012, 1'b0, 1'b0, 16'hABCD, 1'b1, 0, 0);

    // LSU write 0x8000 with nibbles 1,2,3,4
    @(negedge clk);
    lsu_req  = 1'b1;
    lsu_wr   = 1'b1;
    lsu_addr = 16'h8000;
    #1;
    chk_idle("lsu_wr G", 1'b0, 1'b1);
    run_txn("lsu_wr", 16'h8000, 1'b1, 1'b1, 16'h1234, 1'b1, 0, 0);

    // Both held from reset: fetch, LSU, fetch
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    fch_req  = 1'b1;
    fch_addr = 16'h0100;
    lsu_req  = 1'b1;
    lsu_wr   = 1'b0;
    lsu_addr = 16'h0200;
    #1;
    chk_idle("rr G0", 1'b1, 1'b0);
    run_txn("rr fch0", 16'h0100, 1'b0, 1'b0, 16'h1357, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    chk_idle("rr G1", 1'b0, 1'b1);
    run_txn("rr lsu", 16'h0200, 1'b0, 1'b1, 16'h2468, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    chk_idle("rr G2", 1'b1, 1'b0);
    run_txn("rr fch1", 16'h0100, 1'b0, 1'b0, 16'hF00D, 1'b1, 0, 0);

    // LSU request arriving at G+5 of a fetch waits for IDLE
    @(negedge clk);
    fch_req  = 1'b1;
    fch_addr = 16'h0012;
    lsu_wr   = 1'b1;
    lsu_addr = 16'h8000;
    #1;
    chk_idle("mid G", 1'b1, 1'b0);
    run_txn("mid fch", 16'h0012, 1'b0, 1'b0, 16'h4321, 1'b1, 5, 0);
    @(negedge clk);
    #1;
    chk_idle("mid G+16", 1'b0, 1'b1);
    run_txn("mid lsu_wr", 16'h8000, 1'b1, 1'b1, 16'hC0DE, 1'b1, 0, 0);

    // Reset at G+12 of a read, then the held fetch is re-granted
    @(negedge clk);
    fch_req  = 1'b1;
    fch_addr = 16'h1234;
    #1;
    chk_idle("abort G", 1'b1, 1'b0);
    run_txn("abort", 16'h1234, 1'b0, 1'b0, 16'h5A5A, 1'b0, 0, 12);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle("retry G", 1'b1, 1'b0);
    run_txn("retry", 16'h1234, 1'b0, 1'b0, 16'h9E3C, 1'b1, 0, 0);
    @(negedge clk);
    #1;
    chk_idle("final", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/idli_sqi_ctrl_m.md
Name: idli_sqi_ctrl_m

Overview:
SQI (quad-SPI) memory controller that shares the single external serial RAM between instruction fetch and the load/store unit. It sequences each 16b word transaction as command, address, dummy (reads only) and four data nibbles, one nibble per cycle. Read nibbles stream out on a 4b valid-qualified bus that feeds the decoder's encoding input directly. Arbitration between the two requesters is round-robin at transaction granularity.

Parameters:
ADDR_W, 16, word address width; the 24b byte address sent to memory is {zero-pad, addr, 1'b0}.
CMD_RD, 8'h03, SQI read command.
CMD_WR, 8'h02, SQI write command.
DUMMY_CYC, 2, dummy nibble cycles between address and read data.

Ports:
i_sqi_gck  in  1  clock
i_sqi_rst  in  1  asynchronous active-high reset
i_sqi_fch_req  in  1  fetch read request, held until ack
i_sqi_fch_addr  in  ADDR_W  fetch word address
o_sqi_fch_ack  out  1  fetch request granted (1-cycle pulse)
i_sqi_lsu_req  in  1  LSU request, held until ack
i_sqi_lsu_wr  in  1  1=write, 0=read
i_sqi_lsu_addr  in  ADDR_W  LSU word address
o_sqi_lsu_ack  out  1  LSU request granted (1-cycle pulse)
i_sqi_lsu_wdata  in  4  write nibble, sampled when wdata_rdy=1
o_sqi_lsu_wdata_rdy  out  1  LSU must present next write nibble this cycle
o_sqi_rd_data  out  4  read nibble ([15:12] first)
o_sqi_rd_vld  out  1  rd_data valid; high 4 consecutive cycles per read
o_sqi_rd_src  out  1  owner of rd_data: 0=fetch, 1=LSU
o_sqi_cs_n  out  1  memory chip select, active low
o_sqi_sio_out  out  4  nibble driven to memory
o_sqi_sio_oe  out  1  pad output enable
i_sqi_sio_in  in  4  nibble from memory, sampled on rising edge

Behaviour:
- Reset (async, active-high): state IDLE, cs_n=1, oe=0, sio_out=0, acks=0, wdata_rdy=0, rd_vld=0, rd_src=0, rd_data=0, last-grant=LSU (fetch wins first tie). Reset mid-transaction aborts it and nothing is reported; the requester re-requests after reset.
- States: IDLE -> CMD(2) -> ADDR(6) -> DUMMY(DUMMY_CYC, reads only) -> DATA(4) -> END(1) -> IDLE. A 3b cycle counter indexes the nibble within each state.
- Grant, cycle G (in IDLE): if exactly one requester is asserted, grant it. If both are asserted, grant the one not granted last. Pulse the matching ack in G. Latch op, addr and source. Requests seen in any non-IDLE state are ignored.
- Read timeline: CMD G+1..G+2, ADDR G+3..G+8, DUMMY G+9..G+10, DATA G+11..G+14, END G+15, next grant possible at G+16.
- Write timeline: CMD G+1..G+2, ADDR G+3..G+8, DATA G+9..G+12, END G+13, next grant at G+14.
- cs_n=0 in CMD/ADDR/DUMMY/DATA; 1 in IDLE/END. END is the mandatory CS-high gap between back-to-back transactions.
- oe=1 in CMD, ADDR and write DATA; 0 otherwise. sio_out=0 whenever oe=0.
- All nibbles are MSB first: command [7:4] then [3:0]; address bits [23:20] down to [3:0]; data [15:12] down to [3:0].
- Read DATA: rd_data=i_sqi_sio_in (combinational pass-through), rd_vld=1 and rd_src=latched source for all 4 cycles with no gaps. This meets the decoder's valid-for-four-cycles contract.
- Write DATA: wdata_rdy=1; sio_out=i_sqi_lsu_wdata in the same cycle. The LSU has no backpressure and must supply the nibble every rdy cycle.
- rd_vld and wdata_rdy are never asserted outside DATA.
- Address: byte address = zero-extend({addr, 1'b0}) to 24b. Addresses wrap silently within the memory.

Decomposition:
- idli_pkg: sqi_state_t enum (IDLE, CMD, ADDR, DUMMY, DATA, END), SQI_CMD_RD/SQI_CMD_WR constants, sqi_src_t (SRC_FCH=0, SRC_LSU=1).
- Sub-module idli_sqi_arb_m: 2-way round-robin arbiter with last-grant flop. Inputs: both reqs and a grant-enable (state==IDLE). Outputs: one-hot grant. Reset to last=LSU.

Test Plan:
- Fetch read addr 16'h0012, memory returns 4'hA,B,C,D -> sio_out 0,3 then 0,0,0,0,2,4 on G+1..G+8; rd_vld G+11..G+14 with data A,B,C,D and rd_src=0; cs_n high G+15.
- LSU write addr 16'h8000, wdata 1,2,3,4 -> cmd nibbles 0,2; addr nibbles 0,1,0,0,0,0; sio_out 1,2,3,4 with oe=1 and wdata_rdy=1 G+9..G+12; cs_n high G+13.
- Fetch and LSU both requesting from reset -> fetch acked first, LSU acked at G+16, fetch next; no two consecutive grants to the same source while both are held.
- LSU request arriving mid-fetch (G+5) -> no ack until fetch IDLE at G+16; ack then in that cycle.
- Reset asserted at G+12 of a read -> next edge cs_n=1, rd_vld=0, oe=0, state IDLE; after release a held fetch request is re-granted and completes normally.
- Dummy cycles: sio_in driven to 4'hF during G+9..G+10 -> rd_vld stays 0 and oe=0 there.
